// File: rtl/matmul_ctrl.sv
// N x N unsigned matrix-multiply sequencer: streams X/Y reads, accumulates modulo 2**DATA_WIDTH, writes Z.
// Optional build macro MATMUL_CTRL_ABORT_EN adds an 'abort' input that cancels a run in progress.
module matmul_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
`ifdef MATMUL_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_rd_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  output logic [ADDR_WIDTH-1:0] y_rd_addr,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_wr_addr,
  output logic                  z_wr_en,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic [31:0]           cycle_count
);

  localparam logic [ADDR_WIDTH-1:0] N_A  = ADDR_WIDTH'(VECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   i_idx, j_idx, k_idx;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   acc_p1;
  logic                    abort_req;

  // Unsigned product truncated to DATA_WIDTH, accumulated with natural wrap.
  function automatic logic [DATA_WIDTH-1:0] wrap_mac(input logic [DATA_WIDTH-1:0] acc,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] prod;
    prod = a * b;
    return acc + prod;
  endfunction

`ifdef MATMUL_CTRL_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign z_din = acc_p1;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    z_wr_en   = 1'b0;
    x_rd_addr = '0;
    y_rd_addr = '0;
    z_wr_addr = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        x_rd_addr = i_idx * N_A + k_idx;
        y_rd_addr = k_idx * N_A + j_idx;
        if (k_idx == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        z_wr_en   = 1'b1;
        z_wr_addr = i_idx * N_A + j_idx;
        state_nxt = ((i_idx == LAST) && (j_idx == LAST)) ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      i_idx       <= '0;
      j_idx       <= '0;
      k_idx       <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
      vld_p1      <= 1'b0;
      acc_p1      <= '0;
    end else begin
      state <= state_nxt;
      // Stage p0 -> p1: read data returns one cycle after its address was issued in RUN.
      vld_p1 <= (state == RUN) && !abort_req;
      if (busy) cycle_count <= cycle_count + 32'd1;
      if (abort_req) begin
        acc_p1 <= '0;
        k_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              done        <= 1'b0;
              cycle_count <= '0;
              i_idx       <= '0;
              j_idx       <= '0;
              k_idx       <= '0;
              acc_p1      <= '0;
            end
          end
          RUN: begin
            k_idx <= k_idx + 1'b1;
            if (vld_p1) acc_p1 <= wrap_mac(acc_p1, x_dout, y_dout);
          end
          DRAIN: begin
            acc_p1 <= wrap_mac(acc_p1, x_dout, y_dout);
          end
          WRITE: begin
            acc_p1 <= '0;
            k_idx  <= '0;
            if (j_idx == LAST) begin
              j_idx <= '0;
              if (i_idx == LAST) begin
                i_idx <= '0;
                done  <= 1'b1;
              end else begin
                i_idx <= i_idx + 1'b1;
              end
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl: behavioural X/Y/Z buffers, expected Z writes queued at start.
`timescale 1ns/1ps
module tb_matmul_ctrl;
  localparam int DW = 32, AW = 6, N = 8, NN = 64, LAT = 640;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
`ifdef MATMUL_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy, done, z_wr_en;
  logic [AW-1:0] x_rd_addr, y_rd_addr, z_wr_addr;
  logic [DW-1:0] x_dout, y_dout, z_din;
  logic [31:0]   cycle_count;

  logic [DW-1:0] xmem [NN];
  logic [DW-1:0] ymem [NN];
  logic [DW-1:0] zmem [NN];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int chk = 0, pass = 0;
  int cyc = 0, wr_count = 0, last_wr_cyc = -1;

  matmul_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef MATMUL_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done),
    .x_rd_addr(x_rd_addr), .x_dout(x_dout),
    .y_rd_addr(y_rd_addr), .y_dout(y_dout),
    .z_wr_addr(z_wr_addr), .z_wr_en(z_wr_en), .z_din(z_din),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    x_dout <= xmem[x_rd_addr];
    y_dout <= ymem[y_rd_addr];
    if (z_wr_en) zmem[z_wr_addr] <= z_din;
  end

  // Scoreboard monitor: every Z write must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset && z_wr_en) begin
      chk++;
      if (sb.size() == 0) begin
        $display("FAIL zwrite_unexpected: addr=%0d data=%h, required no write", z_wr_addr, z_din);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (z_wr_addr !== e.addr || z_din !== e.data)
          $display("FAIL zwrite: got addr=%0d data=%h, required addr=%0d data=%h",
                   z_wr_addr, z_din, e.addr, e.data);
        else pass++;
      end
      if (last_wr_cyc >= 0) begin
        chk++;
        if (cyc - last_wr_cyc != N + 2)
          $display("FAIL zwrite_spacing: got %0d cycles, required %0d", cyc - last_wr_cyc, N + 2);
        else pass++;
      end
      last_wr_cyc = cyc;
      wr_count++;
    end
  end

  task automatic load(input int mode);
    for (int n = 0; n < NN; n++) begin
      case (mode)
        0: begin xmem[n] = ((n / N) == (n % N)) ? 32'd1 : 32'd0; ymem[n] = 32'(n); end
        1: begin xmem[n] = 32'hFFFF_FFFF; ymem[n] = 32'd1; end
        2: begin xmem[n] = 32'd2; ymem[n] = 32'd3; end
        3: begin xmem[n] = ((n / N) == (n % N)) ? 32'd1 : 32'd0; ymem[n] = 32'(n + 100); end
        4: begin xmem[n] = ((n / N) == (n % N)) ? 32'd1 : 32'd0; ymem[n] = 32'(n + 200); end
        5: begin xmem[n] = $urandom; ymem[n] = $urandom; end
        default: begin xmem[n] = 32'd1; ymem[n] = 32'd1; end
      endcase
    end
  endtask

  task automatic push_expected();
    exp_t e;
    logic [DW-1:0] s, p;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          p = xmem[i*N+k] * ymem[k*N+j];
          s = s + p;
        end
        e.addr = AW'(i*N + j);
        e.data = s;
        sb.push_back(e);
      end
  endtask

  // Starts a run (optionally releasing reset on the same edge) and waits for done; lat=-1 on timeout.
  task automatic launch(input int pulse_at, input bit rel, output int lat);
    int n;
    wr_count = 0;
    last_wr_cyc = -1;
    @(negedge clock);
    if (rel) reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 2*LAT) begin
      @(negedge clock);
      n++;
      start = (n == pulse_at);
    end
    start = 1'b0;
    lat = done ? n : -1;
  endtask

  task automatic test_reset();
    logic [3*AW+35:0] obs;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    obs = {busy, done, z_wr_en, x_rd_addr, y_rd_addr, z_wr_addr, cycle_count};
    chk++;
    if (obs !== '0) $display("FAIL reset_state: got %h, required 0", obs);
    else pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_identity();
    int lat;
    load(0);
    push_expected();
    launch(-1, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL ident_latency: got %0d, required %0d", lat, LAT); else pass++;
    chk++; if (cycle_count !== 32'd640) $display("FAIL ident_cycle_count: got %0d, required 640", cycle_count); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL ident_busy_end: got %b, required 0", busy); else pass++;
    chk++; if (wr_count !== NN) $display("FAIL ident_wr_count: got %0d, required %0d", wr_count, NN); else pass++;
    repeat (5) @(negedge clock);
    chk++; if (done !== 1'b1 || cycle_count !== 32'd640)
      $display("FAIL ident_hold: got done=%b count=%0d, required done=1 count=640", done, cycle_count);
    else pass++;
    for (int n = 0; n < NN; n++) begin
      chk++;
      if (zmem[n] !== 32'(n)) $display("FAIL ident_z[%0d]: got %h, required %h", n, zmem[n], 32'(n));
      else pass++;
    end
  endtask

  task automatic test_wrap();
    int lat;
    load(1);
    push_expected();
    launch(-1, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL wrap_latency: got %0d, required %0d", lat, LAT); else pass++;
    for (int n = 0; n < NN; n++) begin
      chk++;
      if (zmem[n] !== 32'hFFFF_FFF8) $display("FAIL wrap_z[%0d]: got %h, required fffffff8", n, zmem[n]);
      else pass++;
    end
  endtask

  task automatic test_pattern();
    int lat;
    load(2);
    push_expected();
    launch(-1, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL pattern_latency: got %0d, required %0d", lat, LAT); else pass++;
    chk++; if (wr_count !== NN) $display("FAIL pattern_wr_count: got %0d, required %0d", wr_count, NN); else pass++;
    for (int n = 0; n < NN; n++) begin
      chk++;
      if (zmem[n] !== 32'h30) $display("FAIL pattern_z[%0d]: got %h, required 00000030", n, zmem[n]);
      else pass++;
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    load(5);
    push_expected();
    launch(100, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL ignored_latency: got %0d, required %0d", lat, LAT); else pass++;
    chk++; if (wr_count !== NN) $display("FAIL ignored_wr_count: got %0d, required %0d", wr_count, NN); else pass++;
    chk++; if (sb.size() !== 0) $display("FAIL ignored_sb_left: got %0d, required 0", sb.size()); else pass++;
  endtask

  task automatic test_start_final();
    int lat;
    load(2);
    push_expected();
    launch(LAT - 1, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL final_latency: got %0d, required %0d", lat, LAT); else pass++;
    repeat (3) @(negedge clock);
    chk++; if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL final_start_ignored: got busy=%b done=%b, required busy=0 done=1", busy, done);
    else pass++;
  endtask

  task automatic test_reset_midrun();
    int lat, n;
    logic [3*AW+35:0] obs;
    load(3);
    push_expected();
    wr_count = 0;
    last_wr_cyc = -1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (n < 300) begin @(negedge clock); n++; end
    reset = 1'b0;
    #1;
    obs = {busy, done, z_wr_en, x_rd_addr, y_rd_addr, z_wr_addr, cycle_count};
    chk++; if (obs !== '0) $display("FAIL midrun_reset_state: got %h, required 0", obs); else pass++;
    chk++; if (wr_count !== 30) $display("FAIL midrun_writes: got %0d, required 30", wr_count); else pass++;
    sb.delete();
    load(4);
    push_expected();
    launch(-1, 1'b1, lat);
    chk++; if (lat !== LAT) $display("FAIL midrun_new_latency: got %0d, required %0d", lat, LAT); else pass++;
    chk++; if (cycle_count !== 32'd640) $display("FAIL midrun_cycle_count: got %0d, required 640", cycle_count); else pass++;
    for (int a = 0; a < NN; a++) begin
      chk++;
      if (zmem[a] !== 32'(a + 200)) $display("FAIL midrun_z[%0d]: got %h, required %h", a, zmem[a], 32'(a + 200));
      else pass++;
    end
  endtask

`ifdef MATMUL_CTRL_ABORT_EN
  task automatic test_abort();
    int lat, n;
    load(6);
    push_expected();
    wr_count = 0;
    last_wr_cyc = -1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (n < 50) begin @(negedge clock); n++; end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk++; if (busy !== 1'b0 || done !== 1'b0 || z_wr_en !== 1'b0)
      $display("FAIL abort_state: got busy=%b done=%b wr=%b, required 0 0 0", busy, done, z_wr_en);
    else pass++;
    chk++; if (wr_count !== 5) $display("FAIL abort_writes: got %0d, required 5", wr_count); else pass++;
    sb.delete();
    repeat (20) @(negedge clock);
    abort = 1'b1;
    repeat (3) @(negedge clock);
    abort = 1'b0;
    chk++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", busy, done);
    else pass++;
    load(0);
    push_expected();
    launch(-1, 1'b0, lat);
    chk++; if (lat !== LAT) $display("FAIL abort_rerun_latency: got %0d, required %0d", lat, LAT); else pass++;
    for (int a = 0; a < NN; a++) begin
      chk++;
      if (zmem[a] !== 32'(a)) $display("FAIL abort_rerun_z[%0d]: got %h, required %h", a, zmem[a], 32'(a));
      else pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_wrap();
    test_pattern();
    test_start_ignored();
    test_start_final();
    test_reset_midrun();
`ifdef MATMUL_CTRL_ABORT_EN
    test_abort();
`endif
    chk++;
    if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
    else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Param DATA_WIDTH, default 32, element width in bits.
REQ-002 Param ADDR_WIDTH, default 6, buffer address width; SHALL satisfy 2**ADDR_WIDTH >= VECTOR_SIZE**2.
REQ-003 Param VECTOR_SIZE, default 8, matrix dimension N (square N x N, row-major).
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to begin a multiply; sampled on the rising edge.
REQ-008 busy  out  1  high while a multiply is in progress.
REQ-009 done  out  1  high after completion until the next accepted start.
REQ-010 x_rd_addr  out  ADDR_WIDTH  X buffer read address.
REQ-011 x_dout  in  DATA_WIDTH  X buffer read data; 1-cycle read latency.
REQ-012 y_rd_addr  out  ADDR_WIDTH  Y buffer read address.
REQ-013 y_dout  in  DATA_WIDTH  Y buffer read data; 1-cycle read latency.
REQ-014 z_wr_addr  out  ADDR_WIDTH  Z buffer write address.
REQ-015 z_wr_en  out  1  Z buffer write enable.
REQ-016 z_din  out  DATA_WIDTH  Z buffer write data.
REQ-017 cycle_count  out  32  number of cycles spent busy in the last or current run.

Function
REQ-018 The block SHALL compute Z[i][j] = sum over k of X[i][k]*Y[k][j] for 0 <= i,j,k < N.
REQ-019 Addressing SHALL be x_rd_addr = i*N+k, y_rd_addr = k*N+j, and z_wr_addr = i*N+j.
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN and WRITE.
REQ-021 IDLE: start=1 SHALL accept the request: clear done, clear cycle_count, set i=j=k=0, and go to RUN.
REQ-022 RUN: each cycle the block SHALL issue addresses for the current k, then increment k. After issuing k=N-1 it SHALL go to DRAIN.
REQ-023 Each product SHALL be accumulated in the cycle after its addresses are issued; DRAIN SHALL accumulate the product for k=N-1.
REQ-024 WRITE: the block SHALL assert z_wr_en for exactly 1 cycle with z_din = acc, then clear acc and k.
REQ-025 WRITE SHALL then advance j; on j wrap (N-1 -> 0) it SHALL advance i, and go to RUN.
REQ-026 After the WRITE of i=j=N-1 the block SHALL go to IDLE with done=1.
REQ-027 Latency SHALL be N+2 cycles per element and N*N*(N+2) cycles from start acceptance to done rising (640 for N=8).
REQ-028 Products SHALL be unsigned and truncated to DATA_WIDTH.
REQ-029 Accumulation SHALL wrap modulo 2**DATA_WIDTH, with no saturation and no overflow flag.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 start coincident with the final WRITE SHALL be ignored; done SHALL still rise.
REQ-032 busy SHALL be 1 in RUN, DRAIN and WRITE, and 0 in IDLE.
REQ-033 cycle_count SHALL increment every busy cycle and hold its value in IDLE.
REQ-034 z_wr_en SHALL be 0 in all states other than WRITE.
REQ-035 Address outputs SHALL be 0 in IDLE.

Reset
REQ-036 reset=0 SHALL immediately force IDLE with busy=0, done=0, z_wr_en=0, all addresses 0, acc=0 and cycle_count=0.
REQ-037 Reset mid-operation SHALL abandon the run with no further Z writes; a partially written Z is permitted.
REQ-038 After reset release the block SHALL accept a new start on the first rising edge.

Configuration
REQ-039 Macro MATMUL_CTRL_ABORT_EN: when defined, the block SHALL add input port abort (1 bit).
REQ-040 With MATMUL_CTRL_ABORT_EN, abort=1 while busy SHALL force IDLE at the next edge with z_wr_en=0, done unchanged (0), and acc cleared.
REQ-041 With MATMUL_CTRL_ABORT_EN, abort in IDLE SHALL have no effect.
REQ-042 Without MATMUL_CTRL_ABORT_EN, the abort port SHALL be absent and the behaviour identical to REQ-018..REQ-038.

Verification
REQ-043 X=identity, Y[n]=n (n=0..63), start -> Z[n]=n for all 64 addresses; done rises 640 cycles after start accepted; cycle_count=640.
REQ-044 X all 0xFFFFFFFF, Y all 0x00000001 -> every Z = 0xFFFFFFF8 (wrap check).
REQ-045 start pulsed again at cycle 100 of a run -> ignored; exactly 64 z_wr_en pulses; done once at cycle 640.
REQ-046 reset driven low at cycle 300 -> all outputs at reset values same cycle; a new start completes correctly with 640-cycle latency.
REQ-047 (ABORT_EN) abort at cycle 50 -> IDLE next cycle, done=0, no z_wr_en after abort; a subsequent run produces correct Z.
REQ-048 X all 2, Y all 3 -> every Z = 0x00000030; z_wr_addr sequence 0..63 in order, one write per N+2 cycles.
